tracklet_proc_sequencer: RTL and testbench
==========================================

# tracklet_proc_sequencer

Per-event controller for the tracklet projection pipeline. It sweeps tracklet-memory read addresses into the projection-calculation stage and counts the projections that stage writes. After the calculation latency drains, it sweeps projection-memory read addresses into the VM projection-routing stage. It then signals event completion. It sits beside the calculation and routing stages in the tracklet top level and replaces their free-running address counters.

## Interface
Parameters:
- ADDR_W, 9, address width of the tracklet and projection memories; depth is 2^ADDR_W
- CALC_LAT, 6, pipeline latency of the projection-calculation stage in cycles
- ROUTE_LAT, 6, pipeline latency of the VM routing stage in cycles

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- en_proc  in  1  start request; sampled only in IDLE
- n_tracklets  in  ADDR_W+1  tracklet count of the event; latched at start
- calc_wr_en  in  1  projection write strobe from the calculation stage
- read_tracklet  out  ADDR_W  tracklet memory read address
- trk_valid  out  1  read_tracklet carries a valid address this cycle
- read_projection  out  ADDR_W  projection memory read address
- proj_valid  out  1  read_projection carries a valid address this cycle
- n_proj  out  ADDR_W+1  projections counted for the current or last event
- overflow  out  1  projection count exceeded memory depth this event
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at event end

## Operation
- **States:** IDLE, CALC, CALC_DRAIN, ROUTE, ROUTE_DRAIN, DONE.
- **IDLE:**
  - When en_proc=1, latch min(n_tracklets, 2^ADDR_W) and go to CALC.
  - On the same transition, clear n_proj and overflow.
- **CALC:**
  - Issue tracklet addresses 0..N-1, one per cycle, with trk_valid=1.
  - After address N-1, go to CALC_DRAIN.
  - If N=0, CALC lasts one cycle with trk_valid=0.
- **CALC_DRAIN:** Hold for CALC_LAT+1 cycles (memory read latency plus stage latency), then:
  - go to ROUTE if n_proj>0;
  - otherwise go to DONE.
- **Projection counting:**
  - Each calc_wr_en=1 seen during CALC or CALC_DRAIN increments n_proj.
  - calc_wr_en in any other state is ignored.
  - n_proj saturates at 2^ADDR_W. A strobe that arrives at saturation sets overflow, which is sticky until the next start.
- **ROUTE:** Issue projection addresses 0..n_proj-1 with proj_valid=1, then go to ROUTE_DRAIN.
- **ROUTE_DRAIN:** Hold for ROUTE_LAT+1 cycles, then go to DONE.
- **DONE:** Assert done=1 for exactly one cycle, then go to IDLE.
- **Holds between sweeps:**
  - n_proj and overflow hold their values until the next start.
  - Address outputs hold their last value when the matching valid signal is 0.
- **Start requests:** en_proc is ignored in every state except IDLE. Back-to-back events therefore always have one IDLE cycle between them.
- **Reset:** Reset at any point, including mid-sweep, forces IDLE at the next edge. All outputs go to 0: addresses, valids, n_proj, overflow, busy, done.

## Timing
- All outputs are registered.
- Event start: en_proc=1 in IDLE at cycle 0 puts read_tracklet=0 with trk_valid=1 on cycle 1.
- For N tracklets and P projections, with 0<N and 0<P:
  - CALC occupies cycles 1..N.
  - CALC_DRAIN occupies cycles N+1..N+CALC_LAT+1.
  - ROUTE occupies the next P cycles.
  - ROUTE_DRAIN occupies the next ROUTE_LAT+1 cycles.
  - done is asserted on the following cycle.
- busy is high from cycle 1 through the done cycle inclusive.
- calc_wr_en in the last CALC_DRAIN cycle is counted, and that count is reflected in the ROUTE length.

## Structure
- Shared package `tracklet_pkg`:
  - state enum;
  - localparams for the drain lengths (CALC_LAT+1, ROUTE_LAT+1);
  - the depth constant 2^ADDR_W.
- Sub-module `addr_sweep`: a loadable count-up address generator with inputs start and length, and outputs addr, valid and last. It is instantiated twice: tracklet sweep and projection sweep.
- A single shared drain counter inside the top FSM serves both drain states.

## Test plan
- **Nominal event:** N=5, three calc_wr_en pulses during CALC, defaults → read_tracklet 0..4 on cycles 1..5; read_projection 0..2 on cycles 13..15; done on cycle 23; n_proj=3; overflow=0.
- **Empty event:** N=0, no strobes → trk_valid never asserts; proj_valid never asserts; done on cycle 9; n_proj=0.
- **Overflow:** N=512, calc_wr_en held high for 513 cycles starting cycle 1 → n_proj=512; overflow=1; read_projection sweeps 0..511.
- **Clamp:** n_tracklets=600 → last trk_valid address is 511, exactly 512 valid cycles.
- **Back-to-back:** en_proc held high continuously → one IDLE cycle (busy=0) between each done and the next trk_valid; en_proc pulses during busy produce no extra event.
- **Reset mid-ROUTE:** reset=1 → all outputs 0 next cycle, state IDLE; en_proc=1 after reset releases starts a fresh event with n_proj cleared.

Source files
------------

// File: rtl/tracklet_pkg.sv
// Shared types and constants for the tracklet projection sequencer:
// FSM state encoding, default pipeline latencies and derived drain/depth values.
package tracklet_pkg;

   localparam int DEF_ADDR_W    = 9;
   localparam int DEF_CALC_LAT  = 6;
   localparam int DEF_ROUTE_LAT = 6;

   // A drain covers the memory read cycle plus the downstream stage latency.
   function automatic int drain_len(input int lat);
      return lat + 1;
   endfunction

   localparam int CALC_DRAIN_LEN  = DEF_CALC_LAT + 1;
   localparam int ROUTE_DRAIN_LEN = DEF_ROUTE_LAT + 1;
   localparam int DEPTH           = 1 << DEF_ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_CALC        = 3'd1,
      S_CALC_DRAIN  = 3'd2,
      S_ROUTE       = 3'd3,
      S_ROUTE_DRAIN = 3'd4,
      S_DONE        = 3'd5
   } state_t;

endpackage

// File: rtl/tracklet_proc_sequencer_addr_sweep.sv
// Loadable count-up address generator: a start pulse sweeps 0..length-1 with
// valid high, after which the last address is held with valid low.
module addr_sweep #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] addr,
   output logic              valid,
   output logic              last
);

   localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              valid_q, valid_d;

   assign last  = valid_q && ({1'b0, addr_q} == (len_q - LEN_ONE));
   assign addr  = addr_q;
   assign valid = valid_q;

   always_comb begin
      addr_d  = addr_q;
      len_d   = len_q;
      valid_d = valid_q;
      if (start) begin
         len_d   = length;
         valid_d = (length != '0);
         // An empty sweep leaves the previous address visible.
         if (length != '0) begin
            addr_d = '0;
         end
      end else if (valid_q) begin
         if (last) begin
            valid_d = 1'b0;
         end else begin
            addr_d = addr_q + ADDR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         len_q   <= len_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/tracklet_proc_sequencer.sv
// Per-event sequencer: sweeps tracklet reads into projection calculation, counts
// the projections written, then sweeps projection reads into VM routing.
import tracklet_pkg::*;

module tracklet_proc_sequencer #(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int CALC_LAT  = DEF_CALC_LAT,
   parameter int ROUTE_LAT = DEF_ROUTE_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_proc,
   input  logic [ADDR_W:0]   n_tracklets,
   input  logic              calc_wr_en,
   output logic [ADDR_W-1:0] read_tracklet,
   output logic              trk_valid,
   output logic [ADDR_W-1:0] read_projection,
   output logic              proj_valid,
   output logic [ADDR_W:0]   n_proj,
   output logic              overflow,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state
);

   localparam int C_DRAIN   = drain_len(CALC_LAT);
   localparam int R_DRAIN   = drain_len(ROUTE_LAT);
   localparam int MAX_DRAIN = (C_DRAIN > R_DRAIN) ? C_DRAIN : R_DRAIN;
   localparam int DRAIN_W   = $clog2(MAX_DRAIN + 1);

   localparam logic [DRAIN_W-1:0] CALC_LAST  = DRAIN_W'(C_DRAIN - 1);
   localparam logic [DRAIN_W-1:0] ROUTE_LAST = DRAIN_W'(R_DRAIN - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [ADDR_W:0]    DEPTH_L    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]    CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [ADDR_W:0]    n_proj_q, n_proj_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, done_q;

   logic               trk_start, proj_start;
   logic               trk_last, proj_last;
   logic [ADDR_W:0]    trk_len;

   assign trk_len = (n_tracklets > DEPTH_L) ? DEPTH_L : n_tracklets;

   addr_sweep #(.ADDR_W(ADDR_W)) u_trk_sweep (
      .clk    (clk),
      .reset  (reset),
      .start  (trk_start),
      .length (trk_len),
      .addr   (read_tracklet),
      .valid  (trk_valid),
      .last   (trk_last)
   );

   // The projection sweep length includes a strobe arriving in the last drain cycle.
   addr_sweep #(.ADDR_W(ADDR_W)) u_proj_sweep (
      .clk    (clk),
      .reset  (reset),
      .start  (proj_start),
      .length (n_proj_d),
      .addr   (read_projection),
      .valid  (proj_valid),
      .last   (proj_last)
   );

   always_comb begin
      state_d    = state_q;
      drain_d    = drain_q;
      n_proj_d   = n_proj_q;
      ovf_d      = ovf_q;
      trk_start  = 1'b0;
      proj_start = 1'b0;

      if ((state_q == S_CALC || state_q == S_CALC_DRAIN) && calc_wr_en) begin
         if (n_proj_q == DEPTH_L) begin
            ovf_d = 1'b1;
         end else begin
            n_proj_d = n_proj_q + CNT_ONE;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (en_proc) begin
               state_d   = S_CALC;
               trk_start = 1'b1;
               n_proj_d  = '0;
               ovf_d     = 1'b0;
            end
         end
         S_CALC: begin
            // An empty event never raises trk_valid, so CALC lasts one cycle.
            if (!trk_valid || trk_last) begin
               state_d = S_CALC_DRAIN;
               drain_d = '0;
            end
         end
         S_CALC_DRAIN: begin
            if (drain_q == CALC_LAST) begin
               if (n_proj_d != '0) begin
                  state_d    = S_ROUTE;
                  proj_start = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               drain_d = drain_q + DRAIN_ONE;
            end
         end
         S_ROUTE: begin
            if (proj_last) begin
               state_d = S_ROUTE_DRAIN;
               drain_d = '0;
            end
         end
         S_ROUTE_DRAIN: begin
            if (drain_q == ROUTE_LAST) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + DRAIN_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         drain_q  <= '0;
         n_proj_q <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         drain_q  <= drain_d;
         n_proj_q <= n_proj_d;
         ovf_q    <= ovf_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
      end
   end

   assign n_proj    = n_proj_q;
   assign overflow  = ovf_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tracklet_proc_sequencer.sv
// Directed bench for tracklet_proc_sequencer: a table of whole events with
// hand-computed timing, plus back-to-back and reset-mid-route sequences.
module tb_tracklet_proc_sequencer;
   import tracklet_pkg::*;

   localparam int AW = DEF_ADDR_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          en_proc;
   logic [AW:0]   n_tracklets;
   logic          calc_wr_en;
   logic [AW-1:0] read_tracklet;
   logic          trk_valid;
   logic [AW-1:0] read_projection;
   logic          proj_valid;
   logic [AW:0]   n_proj;
   logic          overflow;
   logic          busy;
   logic          done;
   logic [2:0]    dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   tracklet_proc_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .en_proc         (en_proc),
      .n_tracklets     (n_tracklets),
      .calc_wr_en      (calc_wr_en),
      .read_tracklet   (read_tracklet),
      .trk_valid       (trk_valid),
      .read_projection (read_projection),
      .proj_valid      (proj_valid),
      .n_proj          (n_proj),
      .overflow        (overflow),
      .busy            (busy),
      .done            (done),
      .dbg_state       (dbg_state)
   );

   always #5 clk = ~clk;

   // Each event: tracklet count, strobe window [wr_start, wr_start+wr_cnt) in
   // event cycles (cycle 0 = en_proc in IDLE), and hand-computed results.
   typedef struct {
      int n_trk;
      int wr_start;
      int wr_cnt;
      int exp_trk;
      int exp_nproj;
      int exp_ovf;
      int exp_first_proj;
      int exp_done;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_event(input string tag, input vec_t v);
      int cyc, trk_n, proj_n, first_trk, first_proj, done_cyc, done_n, busy_n, ovf_at_done, np_at_done;
      int trk_hold, proj_hold;
      cyc = 0; trk_n = 0; proj_n = 0; first_trk = -1; first_proj = -1;
      done_cyc = -1; done_n = 0; busy_n = 0; ovf_at_done = 0; np_at_done = 0;
      trk_hold = 0; proj_hold = 0;
      en_proc     = 1'b1;
      n_tracklets = (AW+1)'(v.n_trk);
      calc_wr_en  = (v.wr_start == 0 && v.wr_cnt > 0);
      while (done_n == 0 && cyc < 3000) begin
         step();
         cyc++;
         if (trk_valid) begin
            chk({tag, "_trk_addr"}, int'(read_tracklet), trk_n);
            if (first_trk < 0) first_trk = cyc;
            trk_n++;
         end
         if (proj_valid) begin
            chk({tag, "_proj_addr"}, int'(read_projection), proj_n);
            if (first_proj < 0) first_proj = cyc;
            proj_n++;
         end
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_cyc    = cyc;
            ovf_at_done = int'(overflow);
            np_at_done  = int'(n_proj);
            trk_hold    = int'(read_tracklet);
            proj_hold   = int'(read_projection);
         end
         en_proc    = 1'b0;
         calc_wr_en = (cyc >= v.wr_start && cyc < v.wr_start + v.wr_cnt);
      end
      calc_wr_en = 1'b0;
      chk({tag, "_done_seen"}, done_n, 1);
      chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
      chk({tag, "_trk_count"}, trk_n, v.exp_trk);
      chk({tag, "_proj_count"}, proj_n, v.exp_nproj);
      chk({tag, "_n_proj"}, np_at_done, v.exp_nproj);
      chk({tag, "_overflow"}, ovf_at_done, v.exp_ovf);
      chk({tag, "_busy_cycles"}, busy_n, v.exp_done);
      if (v.exp_trk > 0) begin
         chk({tag, "_first_trk"}, first_trk, 1);
         chk({tag, "_trk_hold"}, trk_hold, v.exp_trk - 1);
      end
      if (v.exp_nproj > 0) begin
         chk({tag, "_first_proj"}, first_proj, v.exp_first_proj);
         chk({tag, "_proj_hold"}, proj_hold, v.exp_nproj - 1);
      end
      step();
      chk({tag, "_idle_busy"}, int'(busy), 0);
      chk({tag, "_idle_done"}, int'(done), 0);
      chk({tag, "_idle_nproj"}, int'(n_proj), v.exp_nproj);
      chk({tag, "_idle_ovf"}, int'(overflow), v.exp_ovf);
   endtask

   initial begin
      vec_t fresh;
      int   k, r;
      int   b2b_len;

      //         n_trk wr_s wr_n trk    nproj ovf first_proj done
      vecs[0] = '{5,   2,   3,   5,     3,    0,  13,        23};
      vecs[1] = '{0,   0,   0,   0,     0,    0,  0,         9};
      vecs[2] = '{512, 1,   513, 512,   512,  1,  520,       1039};
      vecs[3] = '{600, 0,   0,   DEPTH, 0,    0,  0,         520};
      vecs[4] = '{3,   10,  1,   3,     1,    0,  11,        19};
      vecs[5] = '{2,   9,   4,   2,     1,    0,  10,        18};
      vecs[6] = '{4,   0,   2,   4,     1,    0,  12,        20};

      reset = 1'b1; en_proc = 1'b0; calc_wr_en = 1'b0; n_tracklets = '0;
      repeat (3) step();
      chk("rst_trk_valid", int'(trk_valid), 0);
      chk("rst_proj_valid", int'(proj_valid), 0);
      chk("rst_read_trk", int'(read_tracklet), 0);
      chk("rst_read_proj", int'(read_projection), 0);
      chk("rst_n_proj", int'(n_proj), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_state", int'(dbg_state), int'(S_IDLE));
      reset = 1'b0;
      step();
      chk("post_rst_busy", int'(busy), 0);

      for (int i = 0; i < 7; i++) begin
         run_event($sformatf("vec%0d", i), vecs[i]);
      end

      // Back-to-back: en_proc held high, N=2, no strobes; events repeat every
      // b2b_len+1 cycles with one IDLE cycle between done and the next sweep.
      b2b_len     = 2 + CALC_DRAIN_LEN + 1;
      en_proc     = 1'b1;
      n_tracklets = (AW+1)'(2);
      for (int c = 1; c <= 35; c++) begin
         step();
         k = (c - 1) / (b2b_len + 1);
         r = c - k * (b2b_len + 1);
         chk($sformatf("b2b_busy_c%0d", c), int'(busy), int'(k < 3 && r <= b2b_len));
         chk($sformatf("b2b_done_c%0d", c), int'(done), int'(k < 3 && r == b2b_len));
         chk($sformatf("b2b_trkv_c%0d", c), int'(trk_valid), int'(k < 3 && r <= 2));
         en_proc = (c < 3 * (b2b_len + 1) - 1);
      end
      en_proc = 1'b0;

      // Reset in the middle of ROUTE: N=3, strobes on cycles 1..3.
      en_proc = 1'b1; n_tracklets = (AW+1)'(3); calc_wr_en = 1'b1;
      for (int c = 1; c <= 3 + CALC_DRAIN_LEN + 2; c++) begin
         step();
         en_proc    = 1'b0;
         calc_wr_en = (c <= 3);
      end
      chk("mid_route_proj_valid", int'(proj_valid), 1);
      chk("mid_route_proj_addr", int'(read_projection), 1);
      chk("mid_route_n_proj", int'(n_proj), 3);
      reset = 1'b1;
      step();
      chk("mr_rst_trk_valid", int'(trk_valid), 0);
      chk("mr_rst_proj_valid", int'(proj_valid), 0);
      chk("mr_rst_read_trk", int'(read_tracklet), 0);
      chk("mr_rst_read_proj", int'(read_projection), 0);
      chk("mr_rst_n_proj", int'(n_proj), 0);
      chk("mr_rst_overflow", int'(overflow), 0);
      chk("mr_rst_busy", int'(busy), 0);
      chk("mr_rst_done", int'(done), 0);
      chk("mr_rst_state", int'(dbg_state), int'(S_IDLE));
      reset = 1'b0;
      fresh = '{2, 1, 1, 2, 1, 0, 10, 18};
      run_event("after_reset", fresh);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
